sad_disparity_search: RTL and testbench



---
 rtl/sad_pkg.sv | 32 +++
 rtl/sad_abs_diff.sv | 40 ++++
 rtl/sad_disparity_search.sv | 169 ++++++++++++++++
 tb/tb_sad_disparity_search.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants, width-derivation helpers and FSM encoding for the SAD disparity search.
package sad_pkg;

    function automatic int sad_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int sad_cells(input int mask_size);
        return mask_size * mask_size;
    endfunction

    // Wide enough for CELLS * (2^PIXEL_WIDTH - 1) without overflow.
    function automatic int sad_sum_width(input int pixel_width, input int mask_size);
        return pixel_width + sad_clog2(sad_cells(mask_size));
    endfunction

    function automatic int sad_disp_width(input int num_disp);
        return sad_clog2(num_disp);
    endfunction

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        RESULT = 2'd2
    } sad_state_t;

endpackage

// File: rtl/sad_abs_diff.sv
// Registered absolute-difference stage carrying a valid bit and a sideband tag alongside the data.
module sad_abs_diff #(
    parameter int PIXEL_WIDTH = 8,
    parameter int TAG_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   in_valid,
    input  logic [PIXEL_WIDTH-1:0] in_a,
    input  logic [PIXEL_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    output logic [PIXEL_WIDTH-1:0] out_diff,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    logic                   valid_reg;
    logic [PIXEL_WIDTH-1:0] diff_reg;
    logic [TAG_WIDTH-1:0]   tag_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            diff_reg  <= '0;
            tag_reg   <= '0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                // Subtract the smaller from the larger so the result never wraps.
                diff_reg <= (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);
                tag_reg  <= in_tag;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_diff  = diff_reg;
    assign out_tag   = tag_reg;

endmodule

// File: rtl/sad_disparity_search.sv
// Streaming SAD search over NUM_DISP candidate windows; reports the lowest-SAD window index.
// Optional macro SAD_DISP_THRESH_EN adds sad_thresh / out_confident.
module sad_disparity_search
    import sad_pkg::*;
#(
    parameter int  PIXEL_WIDTH = 8,
    parameter int  MASK_SIZE   = 3,
    parameter int  NUM_DISP    = 16,
    localparam int SUM_WIDTH   = sad_sum_width(PIXEL_WIDTH, MASK_SIZE),
    localparam int DISP_WIDTH  = sad_disp_width(NUM_DISP)
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_left,
    input  logic [PIXEL_WIDTH-1:0] in_right,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DISP_WIDTH-1:0]  out_disp,
`ifdef SAD_DISP_THRESH_EN
    input  logic [SUM_WIDTH-1:0]   sad_thresh,
    output logic                   out_confident,
`endif
    output logic [SUM_WIDTH-1:0]   out_sad
);

    localparam int CELLS  = sad_cells(MASK_SIZE);
    localparam int CELL_W = sad_clog2(CELLS);

    logic clk;
    logic srst;
    assign clk  = S_AXI_ACLK;
    assign srst = S_AXI_ARESET;

    sad_state_t state_reg, state_next;

    logic [CELL_W-1:0]     cell_cnt_reg;
    logic [DISP_WIDTH-1:0] disp_cnt_reg;
    logic [DISP_WIDTH-1:0] win_idx_reg;
    logic [SUM_WIDTH-1:0]  acc_reg;
    logic [SUM_WIDTH-1:0]  best_sad_reg;
    logic [DISP_WIDTH-1:0] best_disp_reg;
    logic [SUM_WIDTH-1:0]  win_sad;

    logic                   accept;
    logic                   last_cell;
    logic                   last_win;
    logic                   final_accept;
    logic                   d_valid;
    logic [PIXEL_WIDTH-1:0] d_diff;
    logic [1:0]             d_tag;
    logic                   d_last_cell;
    logic                   d_last_win;

    assign in_ready     = (state_reg == RUN);
    assign accept       = in_valid && in_ready;
    assign last_cell    = (cell_cnt_reg == CELL_W'(CELLS - 1));
    assign last_win     = (disp_cnt_reg == DISP_WIDTH'(NUM_DISP - 1));
    assign final_accept = accept && last_cell && last_win;

    sad_abs_diff #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .TAG_WIDTH   (2)
    ) u_abs_diff (
        .clk       (clk),
        .srst      (srst),
        .in_valid  (accept),
        .in_a      (in_left),
        .in_b      (in_right),
        .in_tag    ({last_cell, last_win}),
        .out_valid (d_valid),
        .out_diff  (d_diff),
        .out_tag   (d_tag)
    );

    assign d_last_cell = d_tag[1];
    assign d_last_win  = d_tag[0];

    // Input-side position counters.
    always_ff @(posedge clk) begin
        if (srst) begin
            cell_cnt_reg <= '0;
            disp_cnt_reg <= '0;
        end else if (accept) begin
            if (last_cell) begin
                cell_cnt_reg <= '0;
                disp_cnt_reg <= last_win ? '0 : disp_cnt_reg + 1'b1;
            end else begin
                cell_cnt_reg <= cell_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        win_sad = acc_reg + SUM_WIDTH'(d_diff);
    end

    // Accumulate and compare; win_idx_reg follows the diff stage, one cycle behind disp_cnt_reg.
    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg       <= '0;
            win_idx_reg   <= '0;
            best_sad_reg  <= '0;
            best_disp_reg <= '0;
        end else if (d_valid) begin
            if (d_last_cell) begin
                acc_reg     <= '0;
                win_idx_reg <= d_last_win ? '0 : win_idx_reg + 1'b1;
                if ((win_idx_reg == '0) || (win_sad < best_sad_reg)) begin
                    best_sad_reg  <= win_sad;
                    best_disp_reg <= win_idx_reg;
                end
            end else begin
                acc_reg <= win_sad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        out_valid  = 1'b0;
        case (state_reg)
            RUN: begin
                if (final_accept) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign out_disp = best_disp_reg;
    assign out_sad  = best_sad_reg;

`ifdef SAD_DISP_THRESH_EN
    logic [SUM_WIDTH-1:0] thresh_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            thresh_reg <= '0;
        end else if (final_accept) begin
            thresh_reg <= sad_thresh;
        end
    end

    assign out_confident = out_valid && (best_sad_reg <= thresh_reg);
`endif

endmodule

// File: tb/tb_sad_disparity_search.sv
// Directed self-checking bench: 3x3/4-window instance for function and flow control, 15x15 instance for width limits.
module tb_sad_disparity_search;

    logic        clk;
    logic        srst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_left;
    logic [7:0]  in_right;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_disp;
    logic [11:0] out_sad;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_left;
    logic [7:0]  b_in_right;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [0:0]  b_out_disp;
    logic [15:0] b_out_sad;

`ifdef SAD_DISP_THRESH_EN
    logic [11:0] sad_thresh;
    logic        out_confident;
    logic [15:0] b_sad_thresh;
    logic        b_out_confident;
`endif

    int checks;
    int failures;

    sad_disparity_search #(
        .PIXEL_WIDTH (8),
        .MASK_SIZE   (3),
        .NUM_DISP    (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (srst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_disp      (out_disp),
`ifdef SAD_DISP_THRESH_EN
        .sad_thresh    (sad_thresh),
        .out_confident (out_confident),
`endif
        .out_sad       (out_sad)
    );

    sad_disparity_search #(
        .PIXEL_WIDTH (8),
        .MASK_SIZE   (15),
        .NUM_DISP    (2)
    ) dut_big (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (srst),
        .in_valid      (b_in_valid),
        .in_ready      (b_in_ready),
        .in_left       (b_in_left),
        .in_right      (b_in_right),
        .out_valid     (b_out_valid),
        .out_ready     (b_out_ready),
        .out_disp      (b_out_disp),
`ifdef SAD_DISP_THRESH_EN
        .sad_thresh    (b_sad_thresh),
        .out_confident (b_out_confident),
`endif
        .out_sad       (b_out_sad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input int l, input int r, input bit bubbles);
        if (bubbles && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
        in_valid = 1'b1;
        in_left  = 8'(l);
        in_right = 8'(r);
        step();
    endtask

    // One full 4-window search; window 3's last cell uses r3_last so uneven window SADs are possible.
    task automatic search(input string name, input int l, input int r0, input int r1, input int r2,
                          input int r3, input int r3_last, input bit bubbles, input int hold,
                          input int thresh, input int exp_disp, input int exp_sad, input bit exp_conf);
        int rr;
`ifdef SAD_DISP_THRESH_EN
        sad_thresh = 12'(thresh);
`endif
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 9; c++) begin
                case (w)
                    0: rr = r0;
                    1: rr = r1;
                    2: rr = r2;
                    default: rr = (c == 8) ? r3_last : r3;
                endcase
                send_pair(l, rr, bubbles);
            end
        end
        // Keep presenting data through DRAIN/RESULT; none of it may be accepted.
        in_valid = 1'b1;
        in_left  = 8'd0;
        in_right = 8'd255;
        check({name, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({name, "_drain_ready"}, 32'(in_ready), 32'd0);
        step();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_disp"}, 32'(out_disp), 32'(exp_disp));
        check({name, "_sad"}, 32'(out_sad), 32'(exp_sad));
`ifdef SAD_DISP_THRESH_EN
        check({name, "_conf"}, 32'(out_confident), 32'(exp_conf));
`endif
        for (int h = 0; h < hold; h++) begin
            step();
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({name, "_hold_disp"}, 32'(out_disp), 32'(exp_disp));
            check({name, "_hold_sad"}, 32'(out_sad), 32'(exp_sad));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_done_valid"}, 32'(out_valid), 32'd0);
        check({name, "_done_ready"}, 32'(in_ready), 32'd1);
        $display("search %s disp=%0d sad=%0d", name, out_disp, out_sad);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        srst        = 1'b1;
        in_valid    = 1'b0;
        in_left     = '0;
        in_right    = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_left   = '0;
        b_in_right  = '0;
        b_out_ready = 1'b0;
`ifdef SAD_DISP_THRESH_EN
        sad_thresh   = '0;
        b_sad_thresh = '0;
`endif
        repeat (2) step();
        srst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_disp", 32'(out_disp), 32'd0);
        check("rst_out_sad", 32'(out_sad), 32'd0);

        search("equal", 7, 7, 7, 7, 7, 7, 1'b0, 0, 0, 0, 0, 1'b1);
        search("basic", 10, 20, 15, 12, 18, 18, 1'b0, 0, 18, 2, 18, 1'b1);
        search("bubbles", 10, 20, 15, 12, 18, 18, 1'b1, 5, 17, 2, 18, 1'b0);
        search("tie", 10, 7, 11, 9, 13, 4, 1'b0, 1, 100, 1, 9, 1'b1);
        search("max", 255, 0, 0, 0, 0, 0, 1'b0, 0, 2294, 0, 2295, 1'b0);

        // Abort a search part-way through window 1.
        for (int c = 0; c < 9; c++) send_pair(10, 20, 1'b0);
        for (int c = 0; c < 5; c++) send_pair(10, 15, 1'b0);
        in_valid = 1'b0;
        srst     = 1'b1;
        step();
        srst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_disp", 32'(out_disp), 32'd0);
        check("midrst_out_sad", 32'(out_sad), 32'd0);
        search("after_rst_t17", 10, 20, 15, 12, 18, 18, 1'b0, 0, 17, 2, 18, 1'b0);
        search("after_rst_t18", 10, 20, 15, 12, 18, 18, 1'b0, 0, 18, 2, 18, 1'b1);

        // 15x15 mask, all-maximum difference in both windows.
        b_in_valid = 1'b1;
        b_in_left  = 8'd255;
        b_in_right = 8'd0;
        for (int i = 0; i < 450; i++) step();
        b_in_valid = 1'b0;
        check("big_drain_valid", 32'(b_out_valid), 32'd0);
        step();
        check("big_valid", 32'(b_out_valid), 32'd1);
        check("big_disp", 32'(b_out_disp), 32'd0);
        check("big_sad", 32'(b_out_sad), 32'd57375);
`ifdef SAD_DISP_THRESH_EN
        check("big_conf", 32'(b_out_confident), 32'd0);
`endif
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        check("big_done_valid", 32'(b_out_valid), 32'd0);
        $display("search big disp=%0d sad=%0d", b_out_disp, b_out_sad);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
